// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sample FIFO read side: state encodings,
// frame length default and byte-lane positions within a FIFO word.
package adc_pkg;

  localparam int NUM_SPL_DEF = 32;

  // Upper byte lane carries chip A, lower byte lane carries chip B.
  localparam int HI_MSB = 15;
  localparam int HI_LSB = 8;
  localparam int LO_MSB = 7;
  localparam int LO_LSB = 0;

  typedef enum logic [15:0] {
    S_IDLE = 16'h0001,
    S_WAIT = 16'h0002,
    S_CHK0 = 16'h0004,
    S_RD0  = 16'h0008,
    S_HI   = 16'h0010,
    S_CHK1 = 16'h0020,
    S_RD1  = 16'h0040,
    S_LO   = 16'h0080,
    S_SEND = 16'h0100,
    S_DONE = 16'h0200
  } state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo2spl.sv
// Drains NUM_SPL sample pairs from the byte-lane FIFOs per frame, rebuilds the
// 16-bit chip A / chip B samples and offers them on a valid/ready stream.
module fifo2spl
  import adc_pkg::*;
#(
  parameter int NUM_SPL = NUM_SPL_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs,
  output logic        fd,
  input  logic [3:0]  fifo_empty,
  output logic [1:0]  fifo_rxen,
  input  logic [15:0] fifo_rxd,
  output logic        spl_valid,
  input  logic        spl_ready,
  output logic        spl_last,
  output logic [15:0] spl_rxda,
  output logic [15:0] spl_rxdb
);

  localparam int            CW       = cnt_width(NUM_SPL);
  localparam logic [CW-1:0] CNT_LAST = CW'(NUM_SPL - 1);

  state_t        state_reg;
  state_t        state_next;
  logic [15:0]   hi_reg;
  logic [15:0]   lo_reg;
  logic [CW-1:0] cnt_reg;
  logic          rd_ok;
  logic          cnt_at_last;

  assign rd_ok       = ~|fifo_empty;
  assign cnt_at_last = (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: state_next = S_WAIT;
      S_WAIT: if (fs) state_next = S_CHK0;
      S_CHK0: if (rd_ok) state_next = S_RD0;
      S_RD0:  state_next = S_HI;
      S_HI:   state_next = rd_ok ? S_RD1 : S_CHK1;
      S_CHK1: if (rd_ok) state_next = S_RD1;
      S_RD1:  state_next = S_LO;
      S_LO:   state_next = S_SEND;
      S_SEND: if (spl_ready) state_next = cnt_at_last ? S_DONE : S_CHK0;
      // A frame start needs fs to be seen low first, so a held fs parks here.
      S_DONE: if (!fs) state_next = S_WAIT;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    fd        = 1'b0;
    fifo_rxen = 2'b00;
    spl_valid = 1'b0;
    spl_last  = 1'b0;
    case (state_reg)
      S_RD0, S_RD1: fifo_rxen = 2'b11;
      S_SEND: begin
        spl_valid = 1'b1;
        spl_last  = cnt_at_last;
      end
      S_DONE: fd = 1'b1;
      default: ;
    endcase
  end

  // One-cycle read latency: the word requested in RD0/RD1 is on fifo_rxd in HI/LO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_reg  <= '0;
      lo_reg  <= '0;
      cnt_reg <= '0;
    end else begin
      if (state_reg == S_HI) hi_reg <= fifo_rxd;
      if (state_reg == S_LO) lo_reg <= fifo_rxd;
      if (state_reg == S_SEND && spl_ready) begin
        cnt_reg <= cnt_at_last ? '0 : cnt_reg + CW'(1);
      end
    end
  end

  assign spl_rxda = {hi_reg[HI_MSB:HI_LSB], lo_reg[HI_MSB:HI_LSB]};
  assign spl_rxdb = {hi_reg[LO_MSB:LO_LSB], lo_reg[LO_MSB:LO_LSB]};

endmodule

// File: tb/tb_fifo2spl.sv
// Bench for fifo2spl: two instances (NUM_SPL=1 and NUM_SPL=4), each fed by a
// queue-backed FIFO model, with expected pairs held in scoreboard queues.
module tb_fifo2spl;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        last;
  } pair_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        fs4 = 1'b0, ready4 = 1'b0;
  logic [3:0]  empty4 = 4'b0000;
  logic [15:0] rxd4 = '0;
  logic        fd4, valid4, last4;
  logic [1:0]  rxen4;
  logic [15:0] rxda4, rxdb4;

  logic        fs1 = 1'b0, ready1 = 1'b0;
  logic [3:0]  empty1 = 4'b0000;
  logic [15:0] rxd1 = '0;
  logic        fd1, valid1, last1;
  logic [1:0]  rxen1;
  logic [15:0] rxda1, rxdb1;

  fifo2spl #(.NUM_SPL(4)) dut4 (
    .clk(clk), .rst(rst), .fs(fs4), .fd(fd4), .fifo_empty(empty4),
    .fifo_rxen(rxen4), .fifo_rxd(rxd4), .spl_valid(valid4), .spl_ready(ready4),
    .spl_last(last4), .spl_rxda(rxda4), .spl_rxdb(rxdb4)
  );

  fifo2spl #(.NUM_SPL(1)) dut1 (
    .clk(clk), .rst(rst), .fs(fs1), .fd(fd1), .fifo_empty(empty1),
    .fifo_rxen(rxen1), .fifo_rxd(rxd1), .spl_valid(valid1), .spl_ready(ready1),
    .spl_last(last1), .spl_rxda(rxda1), .spl_rxdb(rxdb1)
  );

  logic [15:0] fq4[$];
  logic [15:0] fq1[$];
  pair_t       exp4[$];
  pair_t       exp1[$];

  int cyc = 0, rd4 = 0, rd1 = 0, viol = 0;
  int pass_cnt = 0, total_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rxen4 == 2'b11) rd4 <= rd4 + 1;
    if (rxen1 == 2'b11) rd1 <= rd1 + 1;
    if (rxen4[0] != rxen4[1] || (rxen4 != 2'b00 && empty4 != 4'b0000)) viol <= viol + 1;
    if (rxen1[0] != rxen1[1] || (rxen1 != 2'b00 && empty1 != 4'b0000)) viol <= viol + 1;
  end

  // FIFO models with one-cycle read latency.
  always @(posedge clk) begin
    if (rxen4[0]) rxd4 <= (fq4.size() > 0) ? fq4.pop_front() : 16'hDEAD;
    if (rxen1[0]) rxd1 <= (fq1.size() > 0) ? fq1.pop_front() : 16'hDEAD;
  end

  task automatic push_frame4(input logic [15:0] base_a, input logic [15:0] base_b);
    pair_t p;
    for (int i = 0; i < 4; i++) begin
      p.a    = base_a + 16'(i * 16'h0123);
      p.b    = base_b + 16'(i * 16'h0321);
      p.last = (i == 3);
      fq4.push_back({p.a[15:8], p.b[15:8]});
      fq4.push_back({p.a[7:0], p.b[7:0]});
      exp4.push_back(p);
    end
  endtask

  task automatic flush4();
    fq4.delete();
    exp4.delete();
  endtask

  task automatic wait_hs4(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (valid4 && ready4) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (fd4 !== 1'b0) $display("FAIL reset_fd got=%b want=0", fd4); else pass_cnt++;
    total_cnt++; if (rxen4 !== 2'b00) $display("FAIL reset_rxen got=%b want=00", rxen4); else pass_cnt++;
    total_cnt++; if (valid4 !== 1'b0 || last4 !== 1'b0) $display("FAIL reset_valid_last got=%b%b want=00", valid4, last4); else pass_cnt++;
    total_cnt++; if ({rxda4, rxdb4} !== 32'h0) $display("FAIL reset_data got=%h want=00000000", {rxda4, rxdb4}); else pass_cnt++;
    total_cnt++;
    if ({fd1, rxen1, valid1, last1, rxda1, rxdb1} !== 37'h0)
      $display("FAIL reset_dut1 got=%h want=0", {fd1, rxen1, valid1, last1, rxda1, rxdb1});
    else pass_cnt++;
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_pair();
    pair_t e;
    int rd0;
    bit ok;
    fq1.push_back(16'hA1B1);
    fq1.push_back(16'hA2B2);
    e.a = 16'hA1A2; e.b = 16'hB1B2; e.last = 1'b1;
    exp1.push_back(e);
    rd0 = rd1;
    ready1 = 1'b1;
    fs1 = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (valid1 && ready1) begin ok = 1'b1; break; end
    end
    total_cnt++;
    if (!ok) $display("FAIL single_timeout got=no_valid want=valid");
    else begin
      pass_cnt++;
      e = exp1.pop_front();
      total_cnt++;
      if ({rxda1, rxdb1, last1} !== {e.a, e.b, e.last})
        $display("FAIL single_data got=%h/%h/%b want=%h/%h/%b", rxda1, rxdb1, last1, e.a, e.b, e.last);
      else pass_cnt++;
      total_cnt++; if (fd1 !== 1'b0) $display("FAIL single_fd_early got=%b want=0", fd1); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (fd1 !== 1'b1) $display("FAIL single_fd got=%b want=1", fd1); else pass_cnt++;
    end
    total_cnt++; if (rd1 - rd0 != 2) $display("FAIL single_reads got=%0d want=2", rd1 - rd0); else pass_cnt++;
    fs1 = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (fd1 !== 1'b0) $display("FAIL single_fd_clear got=%b want=0", fd1); else pass_cnt++;
  endtask

  task automatic test_full_frame();
    pair_t e;
    bit ok;
    int t_prev, rd0;
    flush4();
    push_frame4(16'h1000, 16'h8000);
    rd0 = rd4;
    ready4 = 1'b1;
    fs4 = 1'b1;
    t_prev = cyc;
    for (int i = 0; i < 4; i++) begin
      wait_hs4(ok);
      total_cnt++;
      if (!ok) begin $display("FAIL frame_timeout pair=%0d got=no_valid want=valid", i); break; end
      pass_cnt++;
      e = exp4.pop_front();
      total_cnt++;
      if ({rxda4, rxdb4, last4} !== {e.a, e.b, e.last})
        $display("FAIL frame_data pair=%0d got=%h/%h/%b want=%h/%h/%b", i, rxda4, rxdb4, last4, e.a, e.b, e.last);
      else pass_cnt++;
      total_cnt++;
      if (cyc - t_prev != 6) $display("FAIL frame_spacing pair=%0d got=%0d want=6", i, cyc - t_prev);
      else pass_cnt++;
      t_prev = cyc;
    end
    @(negedge clk);
    total_cnt++; if (fd4 !== 1'b1) $display("FAIL frame_fd got=%b want=1", fd4); else pass_cnt++;
    total_cnt++; if (rd4 - rd0 != 8) $display("FAIL frame_reads got=%0d want=8", rd4 - rd0); else pass_cnt++;
    fs4 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_empty_stall();
    pair_t e;
    bit ok;
    flush4();
    push_frame4(16'h2468, 16'h1357);
    ready4 = 1'b1;
    fs4 = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (rxen4 == 2'b11) begin ok = 1'b1; break; end
    end
    total_cnt++; if (!ok) $display("FAIL stall_first_read got=none want=rxen"); else pass_cnt++;
    @(negedge clk);
    empty4 = 4'b0001;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      total_cnt++;
      if (rxen4 !== 2'b00 || valid4 !== 1'b0)
        $display("FAIL stall_hold cyc=%0d got=rxen%b/valid%b want=rxen00/valid0", n, rxen4, valid4);
      else pass_cnt++;
    end
    empty4 = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      wait_hs4(ok);
      total_cnt++;
      if (!ok) begin $display("FAIL stall_timeout pair=%0d got=no_valid want=valid", i); break; end
      pass_cnt++;
      e = exp4.pop_front();
      total_cnt++;
      if ({rxda4, rxdb4, last4} !== {e.a, e.b, e.last})
        $display("FAIL stall_data pair=%0d got=%h/%h/%b want=%h/%h/%b", i, rxda4, rxdb4, last4, e.a, e.b, e.last);
      else pass_cnt++;
    end
    fs4 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_backpressure();
    pair_t e;
    bit ok;
    int rd0;
    flush4();
    push_frame4(16'h5AA5, 16'hC33C);
    ready4 = 1'b0;
    fs4 = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (valid4) begin ok = 1'b1; break; end
    end
    total_cnt++; if (!ok) $display("FAIL bp_valid got=0 want=1"); else pass_cnt++;
    e = exp4.pop_front();
    rd0 = rd4;
    for (int n = 0; n < 10; n++) begin
      total_cnt++;
      if (valid4 !== 1'b1 || {rxda4, rxdb4, last4} !== {e.a, e.b, e.last} || rxen4 !== 2'b00)
        $display("FAIL bp_hold cyc=%0d got=%b/%h/%h/%b/%b want=1/%h/%h/%b/00",
                 n, valid4, rxda4, rxdb4, last4, rxen4, e.a, e.b, e.last);
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++; if (rd4 != rd0) $display("FAIL bp_reads got=%0d want=0", rd4 - rd0); else pass_cnt++;
    ready4 = 1'b1;
    for (int i = 1; i < 4; i++) begin
      wait_hs4(ok);
      total_cnt++;
      if (!ok) begin $display("FAIL bp_timeout pair=%0d got=no_valid want=valid", i); break; end
      pass_cnt++;
      e = exp4.pop_front();
      total_cnt++;
      if ({rxda4, rxdb4, last4} !== {e.a, e.b, e.last})
        $display("FAIL bp_data pair=%0d got=%h/%h/%b want=%h/%h/%b", i, rxda4, rxdb4, last4, e.a, e.b, e.last);
      else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++; if (fd4 !== 1'b1) $display("FAIL bp_fd got=%b want=1", fd4); else pass_cnt++;
    fs4 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_frame4(input string tag);
    pair_t e;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      wait_hs4(ok);
      total_cnt++;
      if (!ok) begin $display("FAIL %s_timeout pair=%0d got=no_valid want=valid", tag, i); break; end
      pass_cnt++;
      e = exp4.pop_front();
      total_cnt++;
      if ({rxda4, rxdb4, last4} !== {e.a, e.b, e.last})
        $display("FAIL %s_data pair=%0d got=%h/%h/%b want=%h/%h/%b", tag, i, rxda4, rxdb4, last4, e.a, e.b, e.last);
      else pass_cnt++;
      if (i == 0 && tag == "fs_drop") fs4 = 1'b0;
    end
  endtask

  task automatic test_fs_handling();
    int rd0;
    flush4();
    push_frame4(16'h0F0F, 16'hF0F0);
    ready4 = 1'b1;
    fs4 = 1'b1;
    run_frame4("fs_drop");
    @(negedge clk);
    total_cnt++; if (fd4 !== 1'b1) $display("FAIL fs_drop_fd got=%b want=1", fd4); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (fd4 !== 1'b0) $display("FAIL fs_drop_fd_exit got=%b want=0", fd4); else pass_cnt++;

    push_frame4(16'h3141, 16'h5926);
    fs4 = 1'b1;
    run_frame4("fs_hold");
    push_frame4(16'h2718, 16'h2818);
    rd0 = rd4;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      total_cnt++;
      if (fd4 !== 1'b1 || valid4 !== 1'b0 || rxen4 !== 2'b00)
        $display("FAIL fs_hold cyc=%0d got=fd%b/valid%b/rxen%b want=fd1/valid0/rxen00", n, fd4, valid4, rxen4);
      else pass_cnt++;
    end
    total_cnt++; if (rd4 != rd0) $display("FAIL fs_hold_reads got=%0d want=0", rd4 - rd0); else pass_cnt++;
    fs4 = 1'b0;
    @(negedge clk);
    fs4 = 1'b1;
    run_frame4("fs_restart");
    fs4 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    int pulses;
    flush4();
    push_frame4(16'h7777, 16'h9999);
    ready4 = 1'b1;
    fs4 = 1'b1;
    pulses = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (rxen4 == 2'b11) pulses++;
      if (pulses == 2) break;
    end
    total_cnt++; if (pulses != 2) $display("FAIL rstmid_reach_rd1 got=%0d want=2", pulses); else pass_cnt++;
    rst = 1'b0;
    fs4 = 1'b0;
    #1;
    total_cnt++;
    if ({fd4, rxen4, valid4, last4, rxda4, rxdb4} !== 37'h0)
      $display("FAIL rstmid_outputs got=%h want=0", {fd4, rxen4, valid4, last4, rxda4, rxdb4});
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    flush4();
    push_frame4(16'hABCD, 16'h4321);
    @(negedge clk);
    fs4 = 1'b1;
    run_frame4("rstmid");
    @(negedge clk);
    total_cnt++; if (fd4 !== 1'b1) $display("FAIL rstmid_fd got=%b want=1", fd4); else pass_cnt++;
    fs4 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_pair();
    test_full_frame();
    test_empty_stall();
    test_backpressure();
    test_fs_handling();
    test_reset_midframe();
    total_cnt++;
    if (viol != 0) $display("FAIL rxen_protocol got=%0d want=0", viol); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
